// File: rtl/multdiv_ctrl_if.sv
// Handshake between the multiply/divide sequencer and the shared arithmetic unit.
// The sequencer owns operands and start pulses; the unit returns result, exception and ready.
interface multdiv_ctrl_if;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        md_mult;
  logic        md_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;

  modport master (
    output md_operand_a,
    output md_operand_b,
    output md_mult,
    output md_div,
    input  md_result,
    input  md_exception,
    input  md_ready
  );

  modport slave (
    input  md_operand_a,
    input  md_operand_b,
    input  md_mult,
    input  md_div,
    output md_result,
    output md_exception,
    output md_ready
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit beside the execute stage.
// Freezes the pipeline while an operation is in flight and presents a one-cycle write-back.
module multdiv_ctrl #(
  parameter int TIMEOUT    = 40,
  parameter int STATUS_REG = 30,
  parameter int MUL_CODE   = 4,
  parameter int DIV_CODE   = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           op_valid,
  input  logic           op_is_div,
  input  logic [31:0]    operand_a,
  input  logic [31:0]    operand_b,
  input  logic [4:0]     op_rd,
  input  logic           abort,
  multdiv_ctrl_if.master md,
  output logic           stall,
  output logic           busy,
  output logic [4:0]     busy_rd,
  output logic           res_valid,
  output logic [31:0]    res_data,
  output logic [4:0]     res_rd,
  output logic           res_writ
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
  localparam logic [4:0]       STATUS_RD  = 5'(STATUS_REG);
  localparam logic [31:0]      MUL_STATUS = 32'(MUL_CODE);
  localparam logic [31:0]      DIV_STATUS = 32'(DIV_CODE);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             finish;
  logic             fault;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic [4:0]       rd_q;
  logic             is_div_q;
  logic             mult_q;
  logic             div_q;
  logic [CNT_W-1:0] cycle_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    fault      = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid && !abort) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = START;
        end
      end
      START: begin
        stall      = 1'b1;
        state_next = abort ? IDLE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        // Abort beats a late ready; ready beats a coincident timeout.
        if (abort) begin
          state_next = IDLE;
        end else if (md.md_ready) begin
          finish     = 1'b1;
          fault      = md.md_exception;
          state_next = DONE;
        end else if (cycle_cnt == CNT_LAST) begin
          finish     = 1'b1;
          fault      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch, start pulses and BUSY cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      mult_q <= accept && !op_is_div;
      div_q  <= accept && op_is_div;
      if (accept) begin
        op_a_q   <= operand_a;
        op_b_q   <= operand_b;
        rd_q     <= op_rd;
        is_div_q <= op_is_div;
      end
      if (state == START) begin
        cycle_cnt <= '0;
      end else if (state == BUSY && cycle_cnt != CNT_MAX) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

  // Write-back is registered on the BUSY->DONE transition and zero in every other state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_writ  <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= finish;
      res_writ  <= finish && (fault || rd_q != 5'd0);
      if (!finish) begin
        res_rd   <= '0;
        res_data <= '0;
      end else if (fault) begin
        res_rd   <= STATUS_RD;
        res_data <= is_div_q ? DIV_STATUS : MUL_STATUS;
      end else begin
        res_rd   <= rd_q;
        res_data <= md.md_result;
      end
    end
  end

  assign md.md_operand_a = op_a_q;
  assign md.md_operand_b = op_b_q;
  assign md.md_mult      = mult_q;
  assign md.md_div       = div_q;

  // Only the real destination is advertised to decode; the status register never is.
  assign busy    = (state == START) || (state == BUSY);
  assign busy_rd = busy ? rd_q : 5'd0;

endmodule
